// File: rtl/mod_pkg.sv
// Shared definitions for the mod_reduce block: FSM encoding and index sizing.
// The MOD_EARLY_EXIT_EN macro selects the data-dependent start index in mod_reduce.
package mod_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    localparam int WIDTH_DEF = 8;
    localparam int IDX_W     = $clog2(2 * WIDTH_DEF);

    // Bit-index width for a given operand width (dividend is 2*width bits).
    function automatic int idx_width(input int width);
        return $clog2(2 * width);
    endfunction

endpackage

// File: rtl/mod_reduce_if.sv
// Request/response bundle for mod_reduce: requester drives start/in/modulus,
// the reducer returns out/finish/err/busy.
interface mod_reduce_if #(parameter int WIDTH = 8);

    logic                 start;
    logic [2*WIDTH-1:0]   in;
    logic [WIDTH-1:0]     modulus;
    logic [WIDTH-1:0]     out;
    logic                 finish;
    logic                 err;
    logic                 busy;

    modport master (
        output start, in, modulus,
        input  out, finish, err, busy
    );

    modport slave (
        input  start, in, modulus,
        output out, finish, err, busy
    );

endinterface

// File: rtl/mod_msb_find.sv
// Combinational position of the most-significant set bit of a 2*WIDTH vector.
// An all-zero vector reports position 0.
module mod_msb_find
    import mod_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int IW   = idx_width(WIDTH)
) (
    input  logic [2*WIDTH-1:0] vec,
    output logic [IW-1:0]      pos
);

    // Ascending scan: the last set bit seen wins, which is the MSB.
    always_comb begin
        pos = '0;
        for (int i = 0; i < 2 * WIDTH; i++) begin
            if (vec[i]) pos = IW'(i);
        end
    end

endmodule

// File: rtl/mod_reduce.sv
// Bit-serial restoring reduction of a 2*WIDTH dividend modulo a WIDTH divisor.
// Define MOD_EARLY_EXIT_EN to start at the dividend MSB (data-dependent latency).
module mod_reduce
    import mod_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    mod_reduce_if.slave bus
);

    localparam int IW = idx_width(WIDTH);

    state_t               state;
    logic [2*WIDTH-1:0]   in_reg;
    logic [WIDTH-1:0]     n_reg;
    logic [WIDTH:0]       rem;
    logic [IW-1:0]        idx;
    logic [IW-1:0]        start_idx;
    logic [WIDTH-1:0]     out_r;
    logic                 finish_r;
    logic                 err_r;

`ifdef MOD_EARLY_EXIT_EN
    mod_msb_find #(.WIDTH(WIDTH)) u_msb (
        .vec (bus.in),
        .pos (start_idx)
    );
`else
    assign start_idx = IW'(2 * WIDTH - 1);
`endif

    // rem < N holds between steps, so the shifted value stays below 2N and
    // fits in WIDTH+1 bits; one conditional subtract restores the invariant.
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] stepped;

    always_comb begin
        shifted = {rem[WIDTH-1:0], in_reg[idx]};
        stepped = shifted;
        if (shifted >= {1'b0, n_reg}) stepped = shifted - {1'b0, n_reg};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            in_reg   <= '0;
            n_reg    <= '0;
            rem      <= '0;
            idx      <= '0;
            out_r    <= '0;
            finish_r <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            finish_r <= 1'b0;
            err_r    <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.modulus == '0) begin
                            finish_r <= 1'b1;
                            err_r    <= 1'b1;
                            out_r    <= '0;
                        end else begin
                            in_reg <= bus.in;
                            n_reg  <= bus.modulus;
                            rem    <= '0;
                            idx    <= start_idx;
                            state  <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem <= stepped;
                    idx <= idx - IW'(1);
                    if (idx == '0) begin
                        out_r    <= stepped[WIDTH-1:0];
                        finish_r <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.out    = out_r;
    assign bus.finish = finish_r;
    assign bus.err    = err_r;
    assign bus.busy   = (state == CALC);

endmodule

// File: tb/tb_mod_reduce.sv
// Directed + random bench for mod_reduce (WIDTH=8) with a completion scoreboard.
// Expected remainder, err flag and finish cycle are queued at request time.
module tb_mod_reduce;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] out;
        logic         err;
        int           cyc;
        string        tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    mod_reduce_if #(.WIDTH(W)) bus ();

    mod_reduce #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_lat(input logic [2*W-1:0] v);
        int m;
        m = 0;
`ifdef MOD_EARLY_EXIT_EN
        for (int i = 0; i < 2 * W; i++) if (v[i]) m = i;
        return m + 1;
`else
        m = 2 * W;
        return m;
`endif
    endfunction

    // Called at a negedge; start is held for one cycle, returns at the next negedge.
    task automatic issue(input logic [2*W-1:0] v, input logic [W-1:0] n, input string tag);
        exp_t e;
        e.tag = tag;
        if (n == 0) begin
            e.out = '0; e.err = 1'b1; e.cyc = cyc + 1;
        end else begin
            e.out = W'(v % n); e.err = 1'b0; e.cyc = cyc + 1 + exp_lat(v);
        end
        q.push_back(e);
        bus.start = 1'b1; bus.in = v; bus.modulus = n;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_finish(input string tag);
        int n;
        n = 0;
        while (!bus.finish && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_finish_timeout"}, bus.finish, 1'b1);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_drain"}, q.size(), 0);
        @(negedge clk);
    endtask

    // Scoreboard: every finish must match the oldest outstanding request.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.finish) begin
                if (q.size() == 0) begin
                    chk("unexpected_finish", bus.finish, 1'b0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk({e.tag, "_out"}, bus.out, e.out);
                    chk({e.tag, "_err"}, bus.err, e.err);
                    chk({e.tag, "_cycle"}, cyc, e.cyc);
                end
            end else begin
                chk("err_without_finish", bus.err, 1'b0);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        bus.start = 1'b0; bus.in = '0; bus.modulus = '0;
        repeat (3) @(negedge clk);
        chk("rst_out", bus.out, '0);
        chk("rst_finish", bus.finish, 1'b0);
        chk("rst_err", bus.err, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        issue(16'h3039, 8'd97, "r12345m97");
        chk("busy_after_start", bus.busy, 1'b1);
        drain("r12345m97");
        chk("out_hold", bus.out, 8'd26);

        // Back-to-back: second start offered in the cycle finish is high.
        issue(16'hFFFF, 8'd255, "rffffm255");
        wait_finish("rffffm255");
        issue(16'd5, 8'd200, "r5m200");
        chk("b2b_busy", bus.busy, 1'b1);
        drain("r5m200");

        issue(16'd1234, 8'd0, "mod0");
        chk("mod0_busy", bus.busy, 1'b0);
        drain("mod0");
        chk("mod0_busy_after", bus.busy, 1'b0);

        // Starts and operand changes during CALC must not disturb the result.
        issue(16'd50000, 8'd123, "ignore_busy");
        repeat (3) @(negedge clk);
        bus.start = 1'b1; bus.in = 16'h1111; bus.modulus = 8'd3;
        @(negedge clk);
        bus.start = 1'b0; bus.in = 16'hABCD; bus.modulus = 8'd1;
        drain("ignore_busy");

        // Abort mid-operation: no finish, out cleared, then a fresh op.
        issue(16'h3039, 8'd97, "aborted");
        void'(q.pop_back());
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_out", bus.out, '0);
        chk("abort_busy", bus.busy, 1'b0);
        chk("abort_finish", bus.finish, 1'b0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("abort_out_hold", bus.out, '0);
        issue(16'd1000, 8'd7, "r1000m7");
        drain("r1000m7");

`ifdef MOD_EARLY_EXIT_EN
        issue(16'd1, 8'd3, "ee_r1m3");
        drain("ee_r1m3");
        issue(16'd0, 8'd9, "ee_r0");
        drain("ee_r0");
`endif

        for (int i = 0; i < 8; i++) begin
            logic [2*W-1:0] v;
            logic [W-1:0]   n;
            v = 16'($urandom_range(0, 65535));
            n = 8'($urandom_range(1, 255));
            issue(v, n, "rand");
            drain("rand");
        end
        issue(16'hFFFF, 8'd1, "max_m1");
        drain("max_m1");
        issue(16'hFFFE, 8'd255, "fffe_m255");
        drain("fffe_m255");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
